// File: rtl/idx_gen_pkg.sv
// Shared types for the nested index generator: iteration modes, FSM states
// and the mode-code decoder used when a start is accepted.
package idx_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FULL   = 2'd0,
    MODE_BUBBLE = 2'd1,
    MODE_SELECT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The unused code 3 folds onto FULL so the FSM never sees an unnamed mode.
  function automatic mode_e decode_mode(input logic [1:0] code);
    case (code)
      2'd1:    return MODE_BUBBLE;
      2'd2:    return MODE_SELECT;
      default: return MODE_FULL;
    endcase
  endfunction

endpackage

// File: rtl/idx_counter.sv
// One index register with a load-first path and a unit increment. The
// terminal value is supplied one bit wider than the index so it never wraps.
module idx_counter #(
  parameter int SIZE_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [SIZE_ADDR-1:0] i_load_val,
  input  logic                 i_inc,
  input  logic [SIZE_ADDR:0]   i_last_val,
  output logic [SIZE_ADDR-1:0] o_value,
  output logic                 o_at_last
);

  localparam logic [SIZE_ADDR-1:0] STEP = 1;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_value <= '0;
    end else if (i_load) begin
      o_value <= i_load_val;
    end else if (i_inc) begin
      o_value <= o_value + STEP;
    end
  end

  assign o_at_last = ({1'b0, o_value} == i_last_val);

endmodule

// File: rtl/nested_index_gen.sv
// Nested (i, j) index generator with FULL, BUBBLE and SELECT traversal orders.
// Optional abort input enabled by defining NESTED_INDEX_GEN_ABORT_EN.
module nested_index_gen
  import idx_gen_pkg::*;
#(
  parameter int SIZE_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  input  logic [1:0]           i_mode,
  input  logic                 i_start,
  input  logic                 i_en,
`ifdef NESTED_INDEX_GEN_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_valid,
  output logic [SIZE_ADDR-1:0] o_value_i,
  output logic [SIZE_ADDR-1:0] o_value_j,
  output logic                 o_last_j,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [SIZE_ADDR:0]   ONE_X = 1;
  localparam logic [SIZE_ADDR:0]   TWO_X = 2;
  localparam logic [SIZE_ADDR-1:0] ONE   = 1;
  localparam logic [SIZE_ADDR-1:0] TWO   = 2;

  state_e               state;
  mode_e                mode_q;
  mode_e                start_mode;
  logic [SIZE_ADDR-1:0] n_q;
  logic [SIZE_ADDR:0]   n_x, i_x;
  logic [SIZE_ADDR:0]   i_last_val, j_last_val;
  logic                 i_last, j_last;
  logic                 abort, start_ok, start_zero, step;
  logic                 load_i, inc_i, load_j, inc_j;
  logic [SIZE_ADDR-1:0] load_val_j;

`ifdef NESTED_INDEX_GEN_ABORT_EN
  assign abort = (state == RUN) && i_abort;
`else
  assign abort = 1'b0;
`endif

  assign start_mode = decode_mode(i_mode);
  assign start_ok   = (state == IDLE) && i_start;
  assign start_zero = (i_num_elems == '0) ||
                      ((start_mode != MODE_FULL) && ({1'b0, i_num_elems} < TWO_X));
  assign step       = (state == RUN) && o_valid && i_en && !abort;

  // Bounds live at SIZE_ADDR+1 bits so N = 2^SIZE_ADDR-1 cannot wrap.
  assign n_x        = {1'b0, n_q};
  assign i_x        = {1'b0, o_value_i};
  assign i_last_val = (mode_q == MODE_FULL) ? (n_x - ONE_X) : (n_x - TWO_X);
  assign j_last_val = (mode_q == MODE_BUBBLE) ? (n_x - TWO_X - i_x) : (n_x - ONE_X);

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    load_i     = 1'b0;
    inc_i      = 1'b0;
    inc_j      = 1'b0;
    load_val_j = '0;
    if (start_ok && !start_zero) begin
      load_i     = 1'b1;
      load_val_j = (start_mode == MODE_SELECT) ? ONE : '0;
    end else if (step) begin
      if (j_last) begin
        inc_i      = !i_last;
        load_val_j = (mode_q == MODE_SELECT) ? (o_value_i + TWO) : '0;
      end else begin
        inc_j = 1'b1;
      end
    end
    load_j = load_i || inc_i;
  end

  idx_counter #(.SIZE_ADDR(SIZE_ADDR)) u_cnt_i (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (load_i),
    .i_load_val ('0),
    .i_inc      (inc_i),
    .i_last_val (i_last_val),
    .o_value    (o_value_i),
    .o_at_last  (i_last)
  );

  idx_counter #(.SIZE_ADDR(SIZE_ADDR)) u_cnt_j (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (load_j),
    .i_load_val (load_val_j),
    .i_inc      (inc_j),
    .i_last_val (j_last_val),
    .o_value    (o_value_j),
    .o_at_last  (j_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      mode_q  <= MODE_FULL;
      n_q     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            n_q    <= i_num_elems;
            mode_q <= start_mode;
            o_busy <= 1'b1;
            if (start_zero) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state   <= RUN;
              o_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort || (step && j_last && i_last)) begin
            state   <= DONE;
            o_valid <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_last_j = o_valid && j_last;

endmodule

// File: tb/tb_nested_index_gen.sv
// Scoreboard bench for nested_index_gen: directed runs push expected pairs,
// a negedge monitor pops and compares every accepted pair.
module tb_nested_index_gen;
  import idx_gen_pkg::*;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [W-1:0] i_num_elems = '0;
  logic [1:0]   i_mode = 2'd0;
  logic         i_start = 1'b0;
  logic         i_en = 1'b1;
`ifdef NESTED_INDEX_GEN_ABORT_EN
  logic         i_abort = 1'b0;
`endif
  logic         o_valid, o_last_j, o_busy, o_done;
  logic [W-1:0] o_value_i, o_value_j;

  nested_index_gen #(.SIZE_ADDR(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_num_elems (i_num_elems),
    .i_mode      (i_mode),
    .i_start     (i_start),
    .i_en        (i_en),
`ifdef NESTED_INDEX_GEN_ABORT_EN
    .i_abort     (i_abort),
`endif
    .o_valid     (o_valid),
    .o_value_i   (o_value_i),
    .o_value_j   (o_value_j),
    .o_last_j    (o_last_j),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic         last;
  } pair_t;

  pair_t          exp_q[$];
  pair_t          exp_p;
  int             n_cmp = 0;
  int             n_err = 0;
  int             done_seen = 0;
  int             ph = 0;
  bit             chk_done = 1'b0;
  bit             prev_stall = 1'b0;
  bit             stall_en = 1'b0;
  logic [2*W-1:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int j, input bit last);
    pair_t p;
    p.i    = W'(i);
    p.j    = W'(j);
    p.last = last;
    exp_q.push_back(p);
  endtask

  // FULL traversal of an n x n grid, j innermost.
  task automatic push_full(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        push(i, j, j == n - 1);
  endtask

  task automatic kick(input logic [W-1:0] n, input logic [1:0] m);
    done_seen = 0;
    @(posedge i_clk); #1;
    i_num_elems = n;
    i_mode      = m;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int cyc = 0;
    while ((exp_q.size() != 0 || o_busy) && cyc < budget) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    check("finish_in_budget", 32'(cyc < budget), 32'd1);
    check("done_pulse_count", 32'(done_seen), 32'd1);
  endtask

  task automatic wait_pair(input int i, input int j);
    int cyc = 0;
    @(negedge i_clk);
    while (!(o_valid && o_value_i == W'(i) && o_value_j == W'(j)) && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
    end
    check("reach_pair", 32'(cyc < 200), 32'd1);
  endtask

  // Consumer-ready driver: steady high, or 3 low / 1 high when stalling.
  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (stall_en) begin
        ph   = (ph + 1) % 4;
        i_en = (ph == 3);
      end else begin
        i_en = 1'b1;
      end
    end
  end

  // Monitor: compare accepted pairs, hold-while-stalled and done timing.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (chk_done) begin
        check("done_after_last", {30'd0, o_valid, o_done}, 32'b01);
        chk_done = 1'b0;
      end
      if (o_done) done_seen++;
      if (prev_stall)
        check("hold_while_stalled", {15'd0, o_valid, o_value_i, o_value_j}, {15'd0, 1'b1, held});
      prev_stall = o_valid && !i_en;
      held       = {o_value_i, o_value_j};
      if (o_valid && i_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pair: got (%0d,%0d), want no pair (t=%0t)",
                   o_value_i, o_value_j, $time);
        end else begin
          exp_p = exp_q.pop_front();
          check("pair", {15'd0, o_value_i, o_value_j, o_last_j}, {15'd0, exp_p});
          if (exp_q.size() == 0) chk_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("reset_outputs", {12'd0, o_valid, o_value_i, o_value_j, o_last_j, o_busy, o_done}, 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // N=5 BUBBLE
    push(0, 0, 0); push(0, 1, 0); push(0, 2, 0); push(0, 3, 1);
    push(1, 0, 0); push(1, 1, 0); push(1, 2, 1);
    push(2, 0, 0); push(2, 1, 1);
    push(3, 0, 1);
    kick(8'd5, MODE_BUBBLE);
    check("first_valid_bubble", {30'd0, o_valid, o_busy}, 32'b11);
    wait_finish(100);

    // N=4 SELECT, with a second start issued mid-run
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 1);
    push(1, 2, 0); push(1, 3, 1);
    push(2, 3, 1);
    kick(8'd4, MODE_SELECT);
    check("first_valid_select", {31'd0, o_valid}, 32'd1);
    @(posedge i_clk); #1;
    i_num_elems = 8'd5;
    i_mode      = MODE_FULL;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    wait_finish(100);

    // N=3 FULL with consumer stalls
    push_full(3);
    ph       = 0;
    stall_en = 1'b1;
    kick(8'd3, MODE_FULL);
    wait_finish(200);
    stall_en = 1'b0;
    @(posedge i_clk); #1;

    // Zero-pair runs
    kick(8'd1, MODE_SELECT);
    check("zero_done_select1", {30'd0, o_valid, o_done}, 32'b01);
    wait_finish(10);
    kick(8'd0, MODE_FULL);
    check("zero_done_full0", {30'd0, o_valid, o_done}, 32'b01);
    wait_finish(10);
    kick(8'd1, MODE_BUBBLE);
    check("zero_done_bubble1", {30'd0, o_valid, o_done}, 32'b01);
    wait_finish(10);

    // Mode code 3 runs as FULL
    push(0, 0, 0); push(0, 1, 1); push(1, 0, 0); push(1, 1, 1);
    kick(8'd2, 2'd3);
    wait_finish(50);

    // Reset mid-run at (2,1) of N=5 FULL, then restart
    push_full(5);
    kick(8'd5, MODE_FULL);
    wait_pair(2, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("reset_midrun_outputs", {12'd0, o_valid, o_value_i, o_value_j, o_last_j, o_busy, o_done}, 32'd0);
    exp_q.delete();
    chk_done   = 1'b0;
    prev_stall = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("no_resume_after_reset", {29'd0, o_valid, o_busy, o_done}, 32'd0);
    push_full(5);
    kick(8'd5, MODE_FULL);
    check("restart_first_pair", {15'd0, o_valid, o_value_i, o_value_j}, {15'd0, 1'b1, 16'h0000});
    wait_finish(100);

`ifdef NESTED_INDEX_GEN_ABORT_EN
    // Abort at (1,1) of N=5 FULL
    push_full(5);
    kick(8'd5, MODE_FULL);
    wait_pair(1, 1);
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    check("abort_response", {30'd0, o_valid, o_done}, 32'b01);
    i_abort = 1'b0;
    exp_q.delete();
    wait_finish(20);
`endif

    // Largest N in BUBBLE mode: bounds must not wrap
    for (int i = 0; i <= 253; i++)
      for (int j = 0; j <= 253 - i; j++)
        push(i, j, j == 253 - i);
    kick(8'd255, MODE_BUBBLE);
    wait_finish(40000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
